// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: sequences one decoded AHB transfer at a time through APB SETUP/ACCESS phases
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [2:0]        Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);
    typedef enum logic [1:0] {IDLE, WWAIT, SETUP, ENABLE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_d, sel_q, pselx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q, penable_q, hready_q, accept;
    logic [5:0]        region;

    assign region = Haddr[ADDR_W-1 -: 6];

    // Decode the 64 MB slave window, qualify the accept and pick the next state
    always_comb begin
        sel_d   = region == 6'h20 ? 3'b001 :
                  region == 6'h21 ? 3'b010 :
                  region == 6'h22 ? 3'b100 : 3'b000;
        accept  = Valid && hready_q && (sel_d != 3'b000);
        state_d = state_q == WWAIT ? SETUP :
                  state_q == SETUP ? ENABLE :
                  accept ? (Hwrite ? WWAIT : SETUP) : IDLE;
    end

    // State, captured transfer and registered APB/AHB handshake outputs
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            sel_q     <= 3'b000;
            wdata_q   <= '0;
            pselx_q   <= 3'b000;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= Haddr;
                write_q <= Hwrite;
                sel_q   <= sel_d;
            end
            if (state_q == WWAIT)
                wdata_q <= Hwdata;
            pselx_q   <= (state_d == SETUP || state_d == ENABLE) ? (accept ? sel_d : sel_q) : 3'b000;
            penable_q <= state_d == ENABLE;
            hready_q  <= state_d == IDLE || state_d == ENABLE;
        end
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Hreadyout = hready_q;
    assign Paddr     = addr_q;
    assign Pwrite    = write_q;
    assign Pwdata    = wdata_q;
    assign Hrdata    = (penable_q && !write_q) ? Prdata : '0;
endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: vector table, corner sequences and a transaction-schedule model for the APB sequencer
module tb_apb_fsm_controller;
    logic        Hclk = 1'b0, Hreset = 1'b0, Valid = 1'b0, Hwrite = 1'b0;
    logic [31:0] Haddr = '0, Hwdata = '0, Prdata = '0;
    logic        Pwrite, Penable, Hreadyout;
    logic [2:0]  Pselx;
    logic [31:0] Paddr, Pwdata, Hrdata;
    int          n_cmp = 0, n_bad = 0;

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Valid(Valid), .Haddr(Haddr), .Hwrite(Hwrite),
        .Hwdata(Hwdata), .Prdata(Prdata), .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx),
        .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic v; logic [31:0] a; logic w; logic [31:0] wd; logic [31:0] pr;
        logic [2:0] psel; logic pen; logic rdy; logic pw;
        logic [31:0] paddr; logic [31:0] pwdata; logic [31:0] hrdata;
    } vec_t;

    typedef struct { logic [2:0] sel; logic pen; logic rdy; logic ww; } step_t;

    step_t       sched[$];
    logic [31:0] m_addr, m_wdata;
    logic        m_write;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [31:0] pr);
        Valid = v; Haddr = a; Hwrite = w; Hwdata = wd; Prdata = pr;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Pselx"}, {29'd0, Pselx}, 0);
        chk({tag, " Penable"}, {31'd0, Penable}, 0);
        chk({tag, " Pwrite"}, {31'd0, Pwrite}, 0);
        chk({tag, " Paddr"}, Paddr, 0);
        chk({tag, " Pwdata"}, Pwdata, 0);
        chk({tag, " Hrdata"}, Hrdata, 0);
        chk({tag, " Hreadyout"}, {31'd0, Hreadyout}, 1);
    endtask

    function automatic logic [2:0] slave_of(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
            return 3'(1 << ((a - 32'h8000_0000) / 32'h0400_0000));
        return 3'b000;
    endfunction

    task automatic do_reset();
        @(negedge Hclk);
        drive(0, 0, 0, 0, 0);
        Hreset = 1'b1;
        @(negedge Hclk);
        Hreset = 1'b0;
        sched.delete();
        m_addr = '0; m_wdata = '0; m_write = 1'b0;
    endtask

    initial begin
        vec_t  vec[14];
        step_t cur;
        logic [2:0] s;
        logic [31:0] r;

        #1 Hreset = 1'b1;
        #2 chk_reset_vals("por");
        @(negedge Hclk);
        Hreset = 1'b0;

        vec = '{
            '{1, 32'h8000_0010, 0, 32'h0,         32'h11, 3'b000, 0, 1, 0, 32'h0,         32'h0,         32'h0},
            '{0, 32'h8000_0010, 0, 32'h0,         32'h22, 3'b001, 0, 0, 0, 32'h8000_0010, 32'h0,         32'h0},
            '{0, 32'h8000_0010, 0, 32'h0,         32'h33, 3'b001, 1, 1, 0, 32'h8000_0010, 32'h0,         32'h33},
            '{1, 32'h9000_0000, 0, 32'h0,         32'h44, 3'b000, 0, 1, 0, 32'h8000_0010, 32'h0,         32'h0},
            '{1, 32'h8400_0004, 1, 32'h0,         32'h45, 3'b000, 0, 1, 0, 32'h8000_0010, 32'h0,         32'h0},
            '{0, 32'h8400_0004, 1, 32'hDEAD_BEEF, 32'h46, 3'b000, 0, 0, 1, 32'h8400_0004, 32'h0,         32'h0},
            '{0, 32'h8400_0004, 1, 32'h0,         32'h47, 3'b010, 0, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 32'h0},
            '{1, 32'h8800_0000, 0, 32'h0,         32'h55, 3'b010, 1, 1, 1, 32'h8400_0004, 32'hDEAD_BEEF, 32'h0},
            '{1, 32'h8000_0008, 1, 32'h0,         32'h66, 3'b100, 0, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF, 32'h0},
            '{1, 32'h8000_0008, 1, 32'h0,         32'h77, 3'b100, 1, 1, 0, 32'h8800_0000, 32'hDEAD_BEEF, 32'h77},
            '{0, 32'h0,         0, 32'h1234_5678, 32'h88, 3'b000, 0, 0, 1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0},
            '{0, 32'h0,         0, 32'h0,         32'h99, 3'b001, 0, 0, 1, 32'h8000_0008, 32'h1234_5678, 32'h0},
            '{0, 32'h0,         0, 32'h0,         32'hAA, 3'b001, 1, 1, 1, 32'h8000_0008, 32'h1234_5678, 32'h0},
            '{0, 32'h0,         0, 32'h0,         32'hBB, 3'b000, 0, 1, 1, 32'h8000_0008, 32'h1234_5678, 32'h0}
        };

        for (int i = 0; i < 14; i++) begin
            @(negedge Hclk);
            drive(vec[i].v, vec[i].a, vec[i].w, vec[i].wd, vec[i].pr);
            #1;
            chk($sformatf("vec%0d Pselx", i), {29'd0, Pselx}, {29'd0, vec[i].psel});
            chk($sformatf("vec%0d Penable", i), {31'd0, Penable}, {31'd0, vec[i].pen});
            chk($sformatf("vec%0d Hreadyout", i), {31'd0, Hreadyout}, {31'd0, vec[i].rdy});
            chk($sformatf("vec%0d Pwrite", i), {31'd0, Pwrite}, {31'd0, vec[i].pw});
            chk($sformatf("vec%0d Paddr", i), Paddr, vec[i].paddr);
            chk($sformatf("vec%0d Pwdata", i), Pwdata, vec[i].pwdata);
            chk($sformatf("vec%0d Hrdata", i), Hrdata, vec[i].hrdata);
        end

        // read in flight, then asynchronous reset in the middle of its SETUP cycle
        @(negedge Hclk);
        drive(1, 32'h8800_0020, 0, 0, 32'h5);
        @(negedge Hclk);
        drive(0, 0, 0, 0, 32'h5);
        #1 chk("mid SETUP Pselx", {29'd0, Pselx}, 4);
        #2 Hreset = 1'b1;
        #1 chk_reset_vals("mid rd");

        // reset in the SETUP cycle of a write, then a fresh read
        @(negedge Hclk);
        Hreset = 1'b0;
        drive(1, 32'h8400_0004, 1, 0, 0);
        @(negedge Hclk);
        drive(0, 0, 0, 32'hCAFE_F00D, 0);
        @(negedge Hclk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("wr SETUP Pselx", {29'd0, Pselx}, 2);
        chk("wr SETUP Pwdata", Pwdata, 32'hCAFE_F00D);
        #2 Hreset = 1'b1;
        #1 chk_reset_vals("mid wr");
        @(negedge Hclk);
        Hreset = 1'b0;
        drive(1, 32'h8800_0000, 0, 0, 32'h0BAD_F00D);
        #1 chk("post rst rdy", {31'd0, Hreadyout}, 1);
        @(negedge Hclk);
        drive(0, 0, 0, 0, 32'h0BAD_F00D);
        #1;
        chk("post rst SETUP Pselx", {29'd0, Pselx}, 4);
        chk("post rst SETUP rdy", {31'd0, Hreadyout}, 0);
        @(negedge Hclk);
        #1;
        chk("post rst ENABLE Penable", {31'd0, Penable}, 1);
        chk("post rst ENABLE rdy", {31'd0, Hreadyout}, 1);
        chk("post rst ENABLE Hrdata", Hrdata, 32'h0BAD_F00D);

        // random traffic against the transfer-schedule model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge Hclk);
            case ($urandom_range(0, 5))
                0: r = 32'h8000_0000;
                1: r = 32'h8400_0000;
                2: r = 32'h8800_0000;
                3: r = 32'h8C00_0000;
                4: r = 32'h7C00_0000;
                default: r = 32'h9000_0000;
            endcase
            drive($urandom_range(0, 3) != 0, r | ($urandom() & 32'h03FF_FFFF), $urandom_range(0, 1) == 1, $urandom(), $urandom());
            #1;
            cur = sched.size() != 0 ? sched[0] : '{3'b000, 1'b0, 1'b1, 1'b0};
            chk("rnd Pselx", {29'd0, Pselx}, {29'd0, cur.sel});
            chk("rnd Penable", {31'd0, Penable}, {31'd0, cur.pen});
            chk("rnd Hreadyout", {31'd0, Hreadyout}, {31'd0, cur.rdy});
            chk("rnd Pwrite", {31'd0, Pwrite}, {31'd0, m_write});
            chk("rnd Paddr", Paddr, m_addr);
            chk("rnd Pwdata", Pwdata, m_wdata);
            chk("rnd Hrdata", Hrdata, (cur.pen && !m_write) ? Prdata : 32'h0);
            @(posedge Hclk);
            if (cur.ww) m_wdata = Hwdata;
            if (sched.size() != 0) void'(sched.pop_front());
            s = slave_of(Haddr);
            if (cur.rdy && Valid && s != 3'b000) begin
                m_addr = Haddr;
                m_write = Hwrite;
                if (Hwrite) sched.push_back('{3'b000, 1'b0, 1'b0, 1'b1});
                sched.push_back('{s, 1'b0, 1'b0, 1'b0});
                sched.push_back('{s, 1'b1, 1'b1, 1'b0});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
